// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: exception codes, NOP encoding, default reset PC
// and the stage payload layout carried between pipeline stages.
package pipe_pkg;

  localparam int unsigned PC_W_DEF    = 32;
  localparam int unsigned INSTR_W_DEF = 32;
  localparam int unsigned EXC_W_DEF   = 5;

  localparam logic [PC_W_DEF-1:0]    DEFAULT_RESET_PC = 32'h0000_3000;
  localparam logic [INSTR_W_DEF-1:0] NOP_INSTR        = 32'h0000_0000;

  // Exception codes (0 = no exception)
  localparam logic [EXC_W_DEF-1:0] EXC_NONE = 5'd0;
  localparam logic [EXC_W_DEF-1:0] EXC_INT  = 5'd0;
  localparam logic [EXC_W_DEF-1:0] EXC_ADEL = 5'd4;
  localparam logic [EXC_W_DEF-1:0] EXC_ADES = 5'd5;
  localparam logic [EXC_W_DEF-1:0] EXC_SYS  = 5'd8;
  localparam logic [EXC_W_DEF-1:0] EXC_BP   = 5'd9;
  localparam logic [EXC_W_DEF-1:0] EXC_RI   = 5'd10;
  localparam logic [EXC_W_DEF-1:0] EXC_OV   = 5'd12;

  // Stage payload at default widths; field order matches the flat vector used in pipe_stage_reg
  typedef struct packed {
    logic [PC_W_DEF-1:0]    pc;
    logic [PC_W_DEF-1:0]    pcadd4;
    logic [INSTR_W_DEF-1:0] instr;
    logic [EXC_W_DEF-1:0]   exc;
    logic                   bd;
  } stage_payload_t;

endpackage

// File: rtl/pipe_payload_reg.sv
// Single valid + payload register.
// Ports: clk, reset (async active-low), clear (sync invalidate, payload to RST_VAL),
//        load (capture data_in as valid), drop (invalidate, keep payload),
//        valid_q / data_q (registered contents).
module pipe_payload_reg #(
  parameter int unsigned W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic         drop,
  input  logic [W-1:0] data_in,
  output logic         valid_q,
  output logic [W-1:0] data_q
);

  logic         valid_d;
  logic [W-1:0] data_d;

  // clear beats load beats drop; payload only changes on clear or load
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
      data_d  = RST_VAL;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = data_in;
    end else if (drop) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= RST_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake and flush.
// Carries pc, pc+4, instruction, exception code and delay-slot flag.
// Ports: clk, reset (async active-low), flush (sync kill),
//        in_valid/in_ready/in_pc/in_instr/in_exc/in_bd (upstream),
//        out_valid/out_ready/out_pc/out_pcadd4/out_instr/out_exc/out_bd (downstream).
// SKID=1: two-entry skid buffer with registered in_ready; SKID=0: one entry,
// in_ready combinational from out_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned     INSTR_W  = 32,
  parameter int unsigned     PC_W     = 32,
  parameter int unsigned     EXC_W    = 5,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC),
  parameter int unsigned     SKID     = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [EXC_W-1:0]   in_exc,
  input  logic               in_bd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [PC_W-1:0]    out_pcadd4,
  output logic [INSTR_W-1:0] out_instr,
  output logic [EXC_W-1:0]   out_exc,
  output logic               out_bd
);

  localparam int unsigned PL_W = 2 * PC_W + INSTR_W + EXC_W + 1;
  localparam logic [PL_W-1:0] RST_PL =
    {RESET_PC, RESET_PC + PC_W'(4), INSTR_W'(NOP_INSTR), EXC_W'(EXC_NONE), 1'b0};

  logic [PL_W-1:0] in_pl_c;
  logic            m_valid;
  logic [PL_W-1:0] m_data;
  logic            m_clear, m_load, m_drop;
  logic [PL_W-1:0] m_din;

  // pc+4 is computed at capture and wraps modulo 2^PC_W
  assign in_pl_c = {in_pc, in_pc + PC_W'(4), in_instr, in_exc, in_bd};

  // Main register M drives the outputs directly
  pipe_payload_reg #(.W(PL_W), .RST_VAL(RST_PL)) u_main (
    .clk     (clk),
    .reset   (reset),
    .clear   (m_clear),
    .load    (m_load),
    .drop    (m_drop),
    .data_in (m_din),
    .valid_q (m_valid),
    .data_q  (m_data)
  );

  assign out_valid = m_valid;
  assign {out_pc, out_pcadd4, out_instr, out_exc, out_bd} = m_data;

  if (SKID != 0) begin : g_skid
    logic            s_valid;
    logic [PL_W-1:0] s_data;
    logic            s_clear, s_load, s_drop;
    logic            accept_c, m_free_c;
    logic            in_ready_q, in_ready_d;

    pipe_payload_reg #(.W(PL_W), .RST_VAL(RST_PL)) u_skid (
      .clk     (clk),
      .reset   (reset),
      .clear   (s_clear),
      .load    (s_load),
      .drop    (s_drop),
      .data_in (in_pl_c),
      .valid_q (s_valid),
      .data_q  (s_data)
    );

    assign accept_c = in_valid & in_ready_q;
    assign m_free_c = ~m_valid | out_ready;

    // Steering: S always drains into M first so ordering is preserved
    always_comb begin
      m_clear    = flush;
      s_clear    = flush;
      m_load     = 1'b0;
      m_drop     = 1'b0;
      m_din      = in_pl_c;
      s_load     = 1'b0;
      s_drop     = 1'b0;
      in_ready_d = 1'b1;
      if (!flush) begin
        if (m_free_c) begin
          if (s_valid) begin
            m_load = 1'b1;
            m_din  = s_data;
            s_load = accept_c;
            s_drop = ~accept_c;
          end else begin
            m_load = accept_c;
            m_drop = ~accept_c;
          end
        end else begin
          s_load = accept_c;
        end
        // Ready next cycle exactly when S will be empty
        in_ready_d = ~(s_load | (s_valid & ~s_drop));
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) in_ready_q <= 1'b0;
      else        in_ready_q <= in_ready_d;
    end

    assign in_ready = in_ready_q;
  end else begin : g_noskid
    logic in_ready_c;
    logic accept_c;

    // Held low during reset so nothing is offered acceptance while in reset
    assign in_ready_c = reset & (~m_valid | out_ready);
    assign accept_c   = in_valid & in_ready_c;

    always_comb begin
      m_clear = flush;
      m_load  = 1'b0;
      m_drop  = 1'b0;
      m_din   = in_pl_c;
      if (!flush) begin
        m_load = accept_c;
        m_drop = ~accept_c & m_valid & out_ready;
      end
    end

    assign in_ready = in_ready_c;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0, in_bd = 1'b0;
  logic [31:0] in_pc = '0, in_instr = '0;
  logic [4:0]  in_exc = '0;

  logic        ir1, ov1, bd1, ir0, ov0, bd0;
  logic [31:0] pc1, a41, in1, pc0, a40, in0;
  logic [4:0]  ex1, ex0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.SKID(1)) dut_skid (
    .clk(clk), .reset(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(ir1), .in_pc(in_pc), .in_instr(in_instr),
    .in_exc(in_exc), .in_bd(in_bd),
    .out_valid(ov1), .out_ready(out_ready), .out_pc(pc1), .out_pcadd4(a41),
    .out_instr(in1), .out_exc(ex1), .out_bd(bd1));

  pipe_stage_reg #(.SKID(0)) dut_noskid (
    .clk(clk), .reset(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(ir0), .in_pc(in_pc), .in_instr(in_instr),
    .in_exc(in_exc), .in_bd(in_bd),
    .out_valid(ov0), .out_ready(out_ready), .out_pc(pc0), .out_pcadd4(a40),
    .out_instr(in0), .out_exc(ex0), .out_bd(bd0));

  // ---------------- reference model: per design a FIFO of capacity 2 (skid) or 1 ----------
  localparam stage_payload_t RST_PL = '{pc: 32'h3000, pcadd4: 32'h3004, instr: 32'h0, exc: 5'd0, bd: 1'b0};
  stage_payload_t mb [2][2];
  stage_payload_t mh [2];
  int             mc [2];
  bit             mr_skid;

  function automatic bit model_rdy(int k, bit ordy);
    if (k == 0) return mr_skid;
    return rst_n && (mc[1] == 0 || ordy);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mc[k] = 0;
      mh[k] = RST_PL;
    end
    mr_skid = 1'b0;
  endtask

  task automatic model_step(bit fl, bit iv, bit ordy, stage_payload_t p);
    bit rdy [2];
    if (!rst_n) return;
    for (int k = 0; k < 2; k++) rdy[k] = model_rdy(k, ordy);
    for (int k = 0; k < 2; k++) begin
      if (fl) begin
        mc[k] = 0;
        mh[k] = RST_PL;
      end else begin
        if (mc[k] > 0 && ordy) begin
          mh[k]    = mb[k][0];
          mb[k][0] = mb[k][1];
          mc[k]    = mc[k] - 1;
        end
        if (iv && rdy[k]) begin
          mb[k][mc[k]] = p;
          mc[k]        = mc[k] + 1;
        end
      end
    end
    mr_skid = (mc[0] < 2);
  endtask

  function automatic stage_payload_t model_out(int k);
    return (mc[k] > 0) ? mb[k][0] : mh[k];
  endfunction

  // ---------------- checking ----------------
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    stage_payload_t e1, e0;
    e1 = model_out(0);
    e0 = model_out(1);
    chk("skid_out_valid", 32'(ov1), 32'(mc[0] > 0));
    chk("skid_out_pc",    pc1, e1.pc);
    chk("skid_out_pcadd4", a41, e1.pcadd4);
    chk("skid_out_instr", in1, e1.instr);
    chk("skid_out_exc",   32'(ex1), 32'(e1.exc));
    chk("skid_out_bd",    32'(bd1), 32'(e1.bd));
    chk("skid_in_ready",  32'(ir1), 32'(model_rdy(0, out_ready)));
    chk("nosk_out_valid", 32'(ov0), 32'(mc[1] > 0));
    chk("nosk_out_pc",    pc0, e0.pc);
    chk("nosk_out_pcadd4", a40, e0.pcadd4);
    chk("nosk_out_instr", in0, e0.instr);
    chk("nosk_out_exc",   32'(ex0), 32'(e0.exc));
    chk("nosk_out_bd",    32'(bd0), 32'(e0.bd));
    chk("nosk_in_ready",  32'(ir0), 32'(model_rdy(1, out_ready)));
  endtask

  // One clock: drive at the low phase, update model at posedge, check at negedge
  task automatic do_cycle(bit fl, bit iv, bit ordy, logic [31:0] pc, logic [31:0] ins,
                          logic [4:0] exc, bit bd);
    stage_payload_t p;
    flush = fl; in_valid = iv; out_ready = ordy;
    in_pc = pc; in_instr = ins; in_exc = exc; in_bd = bd;
    p = '{pc: pc, pcadd4: pc + 32'd4, instr: ins, exc: exc, bd: bd};
    #1;
    chk("nosk_in_ready_comb", 32'(ir0), 32'(model_rdy(1, ordy)));
    @(posedge clk);
    model_step(fl, iv, ordy, p);
    @(negedge clk);
    check_all();
  endtask

  // ---------------- directed table for the skid variant ----------------
  typedef struct {
    bit fl, iv, ordy;
    logic [31:0] pc, ins;
    logic [4:0] exc;
    bit bd;
    bit e_ov;
    logic [31:0] e_pc, e_a4, e_ins;
    logic [4:0] e_exc;
    bit e_bd, e_ir;
  } vec_t;

  function automatic vec_t mk(bit fl, bit iv, bit ordy, logic [31:0] pc, logic [31:0] ins,
                              logic [4:0] exc, bit bd, bit e_ov, logic [31:0] e_pc,
                              logic [31:0] e_a4, logic [31:0] e_ins, logic [4:0] e_exc,
                              bit e_bd, bit e_ir);
    vec_t v;
    v.fl = fl; v.iv = iv; v.ordy = ordy; v.pc = pc; v.ins = ins; v.exc = exc; v.bd = bd;
    v.e_ov = e_ov; v.e_pc = e_pc; v.e_a4 = e_a4; v.e_ins = e_ins; v.e_exc = e_exc;
    v.e_bd = e_bd; v.e_ir = e_ir;
    return v;
  endfunction

  localparam int NV = 19;
  vec_t tbl [NV];

  initial begin
    // streaming, no bubbles
    tbl[0]  = mk(0,1,1, 32'h3000, 32'h11, 0,0,  1, 32'h3000, 32'h3004, 32'h11, 0,0,1);
    tbl[1]  = mk(0,1,1, 32'h3004, 32'h22, 0,0,  1, 32'h3004, 32'h3008, 32'h22, 0,0,1);
    tbl[2]  = mk(0,1,1, 32'h3008, 32'h33, 0,0,  1, 32'h3008, 32'h300C, 32'h33, 0,0,1);
    tbl[3]  = mk(0,0,1, 32'h0,    32'h0,  0,0,  0, 32'h3008, 32'h300C, 32'h33, 0,0,1);
    // stall: fill M then S, in_ready drops, drain in order
    tbl[4]  = mk(0,1,0, 32'h3000, 32'h44, 0,0,  1, 32'h3000, 32'h3004, 32'h44, 0,0,1);
    tbl[5]  = mk(0,1,0, 32'h3004, 32'h55, 0,0,  1, 32'h3000, 32'h3004, 32'h44, 0,0,0);
    tbl[6]  = mk(0,1,0, 32'h3008, 32'h66, 0,0,  1, 32'h3000, 32'h3004, 32'h44, 0,0,0);
    tbl[7]  = mk(0,1,1, 32'h3008, 32'h66, 0,0,  1, 32'h3004, 32'h3008, 32'h55, 0,0,1);
    tbl[8]  = mk(0,1,1, 32'h3008, 32'h66, 0,0,  1, 32'h3008, 32'h300C, 32'h66, 0,0,1);
    tbl[9]  = mk(0,0,1, 32'h0,    32'h0,  0,0,  0, 32'h3008, 32'h300C, 32'h66, 0,0,1);
    // flush with both entries full
    tbl[10] = mk(0,1,0, 32'h3100, 32'h77, 0,0,  1, 32'h3100, 32'h3104, 32'h77, 0,0,1);
    tbl[11] = mk(0,1,0, 32'h3104, 32'h88, 0,0,  1, 32'h3100, 32'h3104, 32'h77, 0,0,0);
    tbl[12] = mk(1,1,0, 32'h3108, 32'h99, 0,0,  0, 32'h3000, 32'h3004, 32'h0,  0,0,1);
    tbl[13] = mk(0,0,1, 32'h0,    32'h0,  0,0,  0, 32'h3000, 32'h3004, 32'h0,  0,0,1);
    // accept coincident with flush is dropped
    tbl[14] = mk(1,1,0, 32'h3200, 32'hAA, 0,0,  0, 32'h3000, 32'h3004, 32'h0,  0,0,1);
    tbl[15] = mk(0,0,1, 32'h0,    32'h0,  0,0,  0, 32'h3000, 32'h3004, 32'h0,  0,0,1);
    // exception transport and pc+4 wrap
    tbl[16] = mk(0,1,0, 32'hFFFF_FFFC, 32'h0C, 5'd10,1, 1, 32'hFFFF_FFFC, 32'h0, 32'h0C, 5'd10,1,1);
    tbl[17] = mk(0,0,1, 32'h0,    32'h0,  0,0,  0, 32'hFFFF_FFFC, 32'h0, 32'h0C, 5'd10,1,1);
    tbl[18] = mk(1,0,0, 32'h0,    32'h0,  0,0,  0, 32'h3000, 32'h3004, 32'h0,  0,0,1);

    model_reset();
    repeat (2) @(negedge clk);
    // reset state
    chk("rst_out_valid", 32'(ov1), 32'h0);
    chk("rst_out_pc", pc1, 32'h3000);
    chk("rst_out_pcadd4", a41, 32'h3004);
    chk("rst_out_instr", in1, 32'h0);
    chk("rst_in_ready", 32'(ir1), 32'h0);
    chk("rst_nosk_in_ready", 32'(ir0), 32'h0);
    rst_n = 1'b1;
    do_cycle(0,0,0, 32'h0, 32'h0, 0, 0);
    chk("rst_release_in_ready", 32'(ir1), 32'h1);

    for (int i = 0; i < NV; i++) begin
      do_cycle(tbl[i].fl, tbl[i].iv, tbl[i].ordy, tbl[i].pc, tbl[i].ins, tbl[i].exc, tbl[i].bd);
      chk($sformatf("tbl%0d_ov", i),    32'(ov1), 32'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_pc", i),    pc1, tbl[i].e_pc);
      chk($sformatf("tbl%0d_pcadd4", i), a41, tbl[i].e_a4);
      chk($sformatf("tbl%0d_instr", i), in1, tbl[i].e_ins);
      chk($sformatf("tbl%0d_exc", i),   32'(ex1), 32'(tbl[i].e_exc));
      chk($sformatf("tbl%0d_bd", i),    32'(bd1), 32'(tbl[i].e_bd));
      chk($sformatf("tbl%0d_ir", i),    32'(ir1), 32'(tbl[i].e_ir));
    end

    // no-skid: stalled full M gives in_ready=0 now; releasing out_ready raises it at once
    do_cycle(0,1,0, 32'h4000, 32'hBB, 0,0);
    in_valid = 1'b1; out_ready = 1'b0; in_pc = 32'h4004;
    #1;
    chk("nosk_stall_ready", 32'(ir0), 32'h0);
    do_cycle(0,1,1, 32'h4004, 32'hCC, 0,0);
    chk("nosk_replace_pc", pc0, 32'h4004);
    chk("nosk_replace_valid", 32'(ov0), 32'h1);

    // reset mid-stream with skid M and S full
    do_cycle(0,0,1, 32'h0, 32'h0, 0,0);
    do_cycle(0,1,0, 32'h5000, 32'hD0, 5'd4,0);
    do_cycle(0,1,0, 32'h5004, 32'hD4, 0,1);
    chk("pre_rst_skid_full", 32'(ir1), 32'h0);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_out_valid", 32'(ov1), 32'h0);
    chk("midrst_out_pc", pc1, 32'h3000);
    chk("midrst_out_pcadd4", a41, 32'h3004);
    chk("midrst_out_instr", in1, 32'h0);
    chk("midrst_in_ready", 32'(ir1), 32'h0);
    do_cycle(0,1,1, 32'h5008, 32'hD8, 0,0);
    rst_n = 1'b1;
    do_cycle(0,1,1, 32'h500C, 32'hDC, 0,0);
    chk("postrst_in_ready", 32'(ir1), 32'h1);
    chk("postrst_out_valid", 32'(ov1), 32'h0);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      do_cycle($urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7,
               $urandom_range(0, 9) < 6, rpc, $urandom(),
               5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed IF/ID latch: a generic fetch-to-decode pipeline stage register with a valid/ready handshake instead of a bare enable.
- Carries PC, PC+4, instruction, exception code and branch-delay flag.
- Optional 2-entry skid buffer decouples upstream ready from downstream stall, so in_ready is a register output.
- Flush (eret / exception redirect) inserts a NOP bubble; instantiated between F and D, and reusable at later stage boundaries.

Parameters:
- INSTR_W, 32: instruction payload width.
- PC_W, 32: PC width.
- EXC_W, 5: exception code width.
- RESET_PC, 32'h00003000: PC value loaded on reset or flush; PC+4 field loads RESET_PC+4.
- SKID, 1:
  - 1 = 2-entry skid buffer, registered in_ready.
  - 0 = single register, combinational in_ready.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept this cycle.
- in_pc  in  PC_W  PC of incoming instruction.
- in_instr  in  INSTR_W  instruction word.
- in_exc  in  EXC_W  exception code already raised upstream (0 = none).
- in_bd  in  1  instruction is in a branch delay slot.
- out_valid  out  1  output entry present.
- out_ready  in  1  downstream accepts this cycle.
- out_pc  out  PC_W  held PC.
- out_pcadd4  out  PC_W  held PC+4, computed at capture as in_pc+4 modulo 2^PC_W.
- out_instr  out  INSTR_W  held instruction.
- out_exc  out  EXC_W  held exception code.
- out_bd  out  1  held delay-slot flag.

Behaviour:
- Reset (reset=0, asynchronous), all values held while reset is low:
  - out_valid=0, out_pc=RESET_PC, out_pcadd4=RESET_PC+4, out_instr=0, out_exc=0, out_bd=0.
  - Skid entry invalid.
  - in_ready=0 while reset is low; 1 on the first edge after release.
- Handshakes:
  - Accept = in_valid & in_ready.
  - Retire = out_valid & out_ready.
  - Payload is captured only on accept.
  - Latency is 1 cycle: data accepted at edge N is on out_* after edge N.
- Main register M drives out_*. Skid register S exists only when SKID=1.
- SKID=1, per edge:
  - M empty or retiring, S valid: M<=S, S<=accepted entry (if any).
  - M empty or retiring, S empty: M<=accepted entry; M invalid if none.
  - M full and not retiring: accepted entry goes to S.
  - in_ready = !S.valid (registered). Accept is never possible when both are full.
- SKID=0:
  - in_ready = !M.valid | out_ready (combinational).
  - M<=accepted entry when in_ready; otherwise M holds.
- Holding: while not retiring, all out_* are stable, including payload of an invalid M.
- Flush (synchronous, highest priority after reset):
  - M and S are invalidated.
  - out_instr=0 (NOP), out_pc=RESET_PC, out_pcadd4=RESET_PC+4, out_exc=0, out_bd=0.
  - An accept coincident with flush is discarded: upstream sees the handshake complete, but the entry is dropped.
  - in_ready=1 the cycle after a flush.
- Retire on an invalid M is impossible, since out_valid=0.
- out_ready may toggle freely while out_valid=0.
- No combinational path from in_* to out_*.
- No path from out_ready to in_ready when SKID=1.
- PC+4 wraps: in_pc=FFFFFFFC gives out_pcadd4=0.
- Exception code is transported unchanged. Instruction legality is decided in the decode stage, not here.

Decomposition:
- Shared package pipe_pkg holds:
  - EXC_NONE=0, EXC_RI=10 and the other exception code constants.
  - NOP_INSTR=0.
  - The default RESET_PC.
  - The stage-payload struct typedef {pc, pcadd4, instr, exc, bd}.
- One natural sub-module: pipe_payload_reg, a single valid+payload register with load/clear. It is instantiated once for M and once for S (generate on SKID).

Test Plan:
- Reset low mid-stream with M and S full → immediate out_valid=0, out_pc=00003000, out_pcadd4=00003004, out_instr=0; in_ready=1 after the first edge once reset is high.
- SKID=1 streaming, in_valid=out_ready=1, pc=3000,3004,3008 → outputs appear one cycle later in order, in_ready stays 1, no bubbles.
- SKID=1, out_ready=0 for 3 cycles with in_valid=1 → M=3000, S=3004, in_ready=0 from the 2nd edge; on out_ready=1, the sequence 3000, 3004, 3008 appears with no loss or duplication.
- flush=1 while M, S full and accept asserted → next cycle out_valid=0, out_instr=0, out_exc=0, out_pcadd4=00003004; the accepted entry never appears.
- in_exc=10, in_bd=1, in_pc=FFFFFFFC accepted → out_exc=10, out_bd=1, out_pcadd4=00000000.
- SKID=0, out_ready=0 with M full → in_ready=0 in the same cycle; out_ready=1 with in_valid → in_ready=1 combinationally and M replaced on the edge.
